fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h1A000000, address of the first fetch after reset; it shall equal the pc reset value.
REQ-002 Parameter MAX_WAIT, default 15, maximum number of FETCH cycles without MEM_ACK before a bus error.
REQ-003 The block shall use one clock; reset is asynchronous and active-high.
REQ-004 CLK  in  1  system clock; all state changes on its rising edge.
REQ-005 RES  in  1  asynchronous active-high reset.
REQ-006 PC_IN  in  32  current program counter from pc (PC_OUT).
REQ-007 PC_ENABLE  out  1  pc update enable.
REQ-008 PC_MODE  out  1  pc mode: 0 = increment by 4, 1 = load PC_D.
REQ-009 PC_D  out  32  pc load value.
REQ-010 MEM_REQ  out  1  instruction-memory read request.
REQ-011 MEM_ADDR  out  32  read address.
REQ-012 MEM_ACK  in  1  read data valid this cycle.
REQ-013 MEM_RDATA  in  32  read data.
REQ-014 INSTR_VALID  out  1  INSTR/INSTR_PC valid to consumer.
REQ-015 INSTR  out  32  fetched instruction.
REQ-016 INSTR_PC  out  32  address INSTR was fetched from.
REQ-017 INSTR_READY  in  1  consumer accepts INSTR this cycle.
REQ-018 BRANCH_VALID  in  1  redirect request, single-cycle pulse.
REQ-019 BRANCH_TARGET  in  32  redirect address.
REQ-020 BUS_ERR  out  1  sticky fetch-timeout flag.

Function
REQ-021 States: IDLE, FETCH, VALID, ERROR; exit from IDLE to FETCH on the first clock edge after RES deasserts.
REQ-022 In FETCH: MEM_REQ=1 and MEM_ADDR=PC_IN, both combinational; MEM_REQ=0 in all other states.
REQ-023 FETCH with MEM_ACK=1 (no branch): PC_ENABLE=1 and PC_MODE=0 that cycle; INSTR<=MEM_RDATA and INSTR_PC<=PC_IN registered; next state VALID.
REQ-024 VALID: INSTR_VALID=1 with INSTR/INSTR_PC stable; INSTR_READY=1 moves to FETCH (acceptance takes one cycle, so each instruction costs at least 2 cycles).
REQ-025 BRANCH_VALID=1 in IDLE, FETCH or VALID: PC_ENABLE=1, PC_MODE=1, PC_D=BRANCH_TARGET that cycle; next state FETCH; INSTR_VALID=0 from the next cycle.
REQ-026 A branch takes priority over a simultaneous MEM_ACK (data discarded, no increment) and over a simultaneous INSTR_READY (the instruction counts as consumed).
REQ-027 MEM_REQ may drop before MEM_ACK on a branch; a MEM_ACK arriving outside FETCH shall be ignored.
REQ-028 Outside REQ-023/025: PC_ENABLE=0, PC_MODE=0, PC_D=0.
REQ-029 Wait counter, 4 bits min: cleared on entering FETCH and on MEM_ACK, incremented each FETCH cycle without ACK; reaching MAX_WAIT sets BUS_ERR=1 and enters ERROR.
REQ-030 ERROR: all outputs idle except BUS_ERR=1; BRANCH_VALID ignored; exit only by RES.

Reset
REQ-031 While RES=1: state IDLE, wait counter 0; PC_ENABLE, PC_MODE, MEM_REQ, INSTR_VALID, BUS_ERR = 0; PC_D, MEM_ADDR, INSTR, INSTR_PC = 0.
REQ-032 RES mid-operation shall abort any pending fetch without a pc update; the first fetch after reset reads RESET_VECTOR from pc.

Structure
REQ-033 A shared package shall hold the state encoding, RESET_VECTOR and the PC_MODE encodings (increment/load).
REQ-034 One sub-module, fetch_timeout (wait counter + compare), is natural; the rest is a single FSM. pc remains external.

Verification
REQ-035 Reset release, MEM_ACK on the 1st FETCH cycle with RDATA=32'h00000013 -> MEM_ADDR=1A000000; INSTR=00000013, INSTR_PC=1A000000, INSTR_VALID=1; PC_IN=1A000004.
REQ-036 INSTR_READY=0 for 5 cycles in VALID -> INSTR held, no MEM_REQ, PC_IN unchanged; READY=1 -> next fetch at 1A000004.
REQ-037 BRANCH_VALID with TARGET=1A000100 coinciding with MEM_ACK -> PC_MODE=1, PC_D=1A000100, no INSTR_VALID; next MEM_ADDR=1A000100.
REQ-038 MEM_ACK withheld for 15 FETCH cycles -> BUS_ERR=1, ERROR, MEM_REQ=0; a later branch is ignored; RES clears it and fetch restarts at 1A000000.
REQ-039 RES pulsed during FETCH at 1A000008 -> all outputs 0 immediately, no PC_ENABLE pulse, fetch resumes at 1A000000.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encoding, reset vector
// and the pc mode encodings.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StValid,
        StError
    } fetch_state_e;

    localparam logic [31:0] ResetVectorDefault = 32'h1A00_0000;

    localparam logic PcModeInc  = 1'b0;
    localparam logic PcModeLoad = 1'b1;

endpackage

// File: rtl/fetch_timeout.sv
// Counts consecutive FETCH cycles without a memory acknowledge and flags the cycle
// on which the limit is reached.
module fetch_timeout #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk_i,
    input  logic res_i,
    input  logic inc_i,
    output logic timeout_o
);

    localparam int unsigned CntW = (MAX_WAIT < 16) ? 4 : $clog2(MAX_WAIT + 1);

    logic [CntW-1:0] count_q, count_d;

    // Any cycle that is not a stalled fetch restarts the count.
    always_comb begin
        count_d = '0;
        if (inc_i) begin
            count_d = count_q + CntW'(1);
        end
    end

    // Fires on the MAX_WAIT-th stalled cycle so ERROR is entered at its end.
    assign timeout_o = inc_i && (count_q == CntW'(MAX_WAIT - 1));

    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the external pc, issues memory reads and
// presents fetched instructions to the consumer with a sticky timeout flag.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = ResetVectorDefault,
    parameter int unsigned MAX_WAIT     = 15
) (
    input  logic        clk_i,
    input  logic        res_i,
    input  logic [31:0] pc_in_i,
    output logic        pc_enable_o,
    output logic        pc_mode_o,
    output logic [31:0] pc_d_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    input  logic        branch_valid_i,
    input  logic [31:0] branch_target_i,
    output logic        bus_err_o
);

    fetch_state_e state_q;
    logic [31:0]  instr_q, instr_pc_q;
    logic         instr_valid_q, bus_err_q;
    logic         wait_inc, timeout;

    assign wait_inc = !res_i && (state_q == StFetch) && !mem_ack_i && !branch_valid_i;

    fetch_timeout #(
        .MAX_WAIT (MAX_WAIT)
    ) u_fetch_timeout (
        .clk_i     (clk_i),
        .res_i     (res_i),
        .inc_i     (wait_inc),
        .timeout_o (timeout)
    );

    // pc control and memory request are same-cycle; reset forces them idle.
    always_comb begin
        pc_enable_o = 1'b0;
        pc_mode_o   = PcModeInc;
        pc_d_o      = '0;
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        if (!res_i) begin
            unique case (state_q)
                StIdle, StValid: begin
                    if (branch_valid_i) begin
                        pc_enable_o = 1'b1;
                        pc_mode_o   = PcModeLoad;
                        pc_d_o      = branch_target_i;
                    end
                end
                StFetch: begin
                    mem_req_o  = 1'b1;
                    mem_addr_o = pc_in_i;
                    if (branch_valid_i) begin
                        pc_enable_o = 1'b1;
                        pc_mode_o   = PcModeLoad;
                        pc_d_o      = branch_target_i;
                    end else if (mem_ack_i) begin
                        pc_enable_o = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            state_q       <= StIdle;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: state_q <= StFetch;
                StFetch: begin
                    if (branch_valid_i) begin
                        state_q <= StFetch;
                    end else if (mem_ack_i) begin
                        instr_q       <= mem_rdata_i;
                        instr_pc_q    <= pc_in_i;
                        instr_valid_q <= 1'b1;
                        state_q       <= StValid;
                    end else if (timeout) begin
                        bus_err_q <= 1'b1;
                        state_q   <= StError;
                    end
                end
                StValid: begin
                    if (branch_valid_i || instr_ready_i) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= StFetch;
                    end
                end
                default: state_q <= StError;
            endcase
        end
    end

    assign instr_valid_o = instr_valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign bus_err_o     = bus_err_q;

    // The external pc must come out of reset holding the address fetched first.
    assert property (@(posedge clk_i) $fell(res_i) |-> pc_in_i == RESET_VECTOR);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural pc alongside the DUT.
module tb_fetch_ctrl;

    localparam logic [31:0] RV = 32'h1A00_0000;

    logic        clk = 1'b0;
    logic        res;
    logic [31:0] pc_q;
    logic        pc_enable, pc_mode;
    logic [31:0] pc_d;
    logic        mem_req, mem_ack;
    logic [31:0] mem_addr, mem_rdata;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        bus_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .RESET_VECTOR (RV),
        .MAX_WAIT     (15)
    ) dut (
        .clk_i           (clk),
        .res_i           (res),
        .pc_in_i         (pc_q),
        .pc_enable_o     (pc_enable),
        .pc_mode_o       (pc_mode),
        .pc_d_o          (pc_d),
        .mem_req_o       (mem_req),
        .mem_addr_o      (mem_addr),
        .mem_ack_i       (mem_ack),
        .mem_rdata_i     (mem_rdata),
        .instr_valid_o   (instr_valid),
        .instr_o         (instr),
        .instr_pc_o      (instr_pc),
        .instr_ready_i   (instr_ready),
        .branch_valid_i  (branch_valid),
        .branch_target_i (branch_target),
        .bus_err_o       (bus_err)
    );

    // Behavioural pc: increment by 4 or load, async reset to the reset vector.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            pc_q <= RV;
        end else if (pc_enable) begin
            pc_q <= pc_mode ? pc_d : pc_q + 32'd4;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // From a FETCH negedge: acknowledge, accept, and return at the next FETCH negedge.
    task automatic fetch_and_accept();
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        instr_ready = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        res = 1'b1;
        mem_ack = 1'b0;
        mem_rdata = '0;
        instr_ready = 1'b0;
        branch_valid = 1'b0;
        branch_target = '0;
        repeat (2) @(posedge clk);
        branch_valid = 1'b1;
        branch_target = 32'h0000_1234;
        @(negedge clk);
        check("rst_pc_enable", pc_enable, 0);
        check("rst_pc_mode", pc_mode, 0);
        check("rst_pc_d", pc_d, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_bus_err", bus_err, 0);
        branch_valid = 1'b0;
        res = 1'b0;

        // First fetch, acknowledged on its first FETCH cycle
        @(posedge clk); #1;
        mem_ack = 1'b1;
        mem_rdata = 32'h0000_0013;
        @(negedge clk);
        check("f1_mem_req", mem_req, 1);
        check("f1_mem_addr", mem_addr, RV);
        check("f1_pc_enable", pc_enable, 1);
        check("f1_pc_mode", pc_mode, 0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("v1_instr_valid", instr_valid, 1);
        check("v1_instr", instr, 32'h0000_0013);
        check("v1_instr_pc", instr_pc, RV);
        check("v1_pc", pc_q, 32'h1A00_0004);
        check("v1_mem_req", mem_req, 0);

        // Consumer stalls for 5 cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_instr_valid", instr_valid, 1);
            check("stall_instr", instr, 32'h0000_0013);
            check("stall_mem_req", mem_req, 0);
            check("stall_pc", pc_q, 32'h1A00_0004);
        end
        instr_ready = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b0;
        @(negedge clk);
        check("f2_mem_req", mem_req, 1);
        check("f2_mem_addr", mem_addr, 32'h1A00_0004);
        check("f2_instr_valid", instr_valid, 0);

        // Branch coinciding with MEM_ACK wins; data discarded
        branch_valid = 1'b1;
        branch_target = 32'h1A00_0100;
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        check("br_pc_enable", pc_enable, 1);
        check("br_pc_mode", pc_mode, 1);
        check("br_pc_d", pc_d, 32'h1A00_0100);
        @(posedge clk); #1;
        branch_valid = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        check("br_instr_valid", instr_valid, 0);
        check("br_mem_addr", mem_addr, 32'h1A00_0100);
        check("br_instr_kept", instr, 32'h0000_0013);

        // Branch in VALID together with READY
        mem_ack = 1'b1;
        mem_rdata = 32'h0000_0055;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("v3_instr", instr, 32'h0000_0055);
        check("v3_instr_pc", instr_pc, 32'h1A00_0100);
        branch_valid = 1'b1;
        branch_target = 32'h1A00_0200;
        instr_ready = 1'b1;
        #1;
        check("brv_pc_d", pc_d, 32'h1A00_0200);
        check("brv_pc_mode", pc_mode, 1);
        @(posedge clk); #1;
        branch_valid = 1'b0;
        instr_ready = 1'b0;
        @(negedge clk);
        check("brv_instr_valid", instr_valid, 0);
        check("brv_mem_addr", mem_addr, 32'h1A00_0200);

        // Timeout: 15 FETCH cycles without ACK
        for (int i = 0; i < 15; i++) begin
            if (i == 14) begin
                check("to14_bus_err", bus_err, 0);
                check("to14_mem_req", mem_req, 1);
            end
            @(negedge clk);
        end
        check("to_bus_err", bus_err, 1);
        check("to_mem_req", mem_req, 0);
        check("to_mem_addr", mem_addr, 0);
        branch_valid = 1'b1;
        branch_target = 32'h1A00_0300;
        #1;
        check("err_br_pc_enable", pc_enable, 0);
        @(negedge clk);
        branch_valid = 1'b0;
        check("err_bus_err", bus_err, 1);
        check("err_pc", pc_q, 32'h1A00_0200);
        check("err_mem_req", mem_req, 0);
        res = 1'b1;
        #1;
        check("err_rst_bus_err", bus_err, 0);
        @(negedge clk);
        res = 1'b0;
        @(negedge clk);
        check("rs_mem_req", mem_req, 1);
        check("rs_mem_addr", mem_addr, RV);

        // Reset pulsed during FETCH at 1A000008 with an ACK present
        fetch_and_accept();
        fetch_and_accept();
        check("f8_mem_addr", mem_addr, 32'h1A00_0008);
        mem_ack = 1'b1;
        #2;
        res = 1'b1;
        #1;
        check("mr_pc_enable", pc_enable, 0);
        check("mr_mem_req", mem_req, 0);
        check("mr_mem_addr", mem_addr, 0);
        check("mr_instr_pc", instr_pc, 0);
        @(negedge clk);
        mem_ack = 1'b0;
        check("mr_pc", pc_q, RV);
        res = 1'b0;
        @(negedge clk);
        check("mr_resume_addr", mem_addr, RV);
        check("mr_resume_req", mem_req, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
